hwpe_tcdm_responder_bank: RTL and testbench

- Memory-side responder for the HWPE TCDM protocol: the slave end that streamer TCDM master ports (load/store FIFOs, sources/sinks) talk to.
- Arbitrates NP TCDM master ports onto one single-ported word-addressed memory array, one grant per cycle, round-robin.
- Returns read data on the granted port after a fixed, parameterised latency.
- Used as the cluster-memory model in HWPE testbenches and as a standalone scratchpad bank behind accelerator streamers.

---
 rtl/hwpe_tcdm_responder_bank.sv | 161 ++++++++++++++++
 tb/tb_hwpe_tcdm_responder_bank.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_tcdm_responder_bank.sv
// hwpe_tcdm_responder_bank
// Memory-side responder for HWPE TCDM masters. NP request ports are arbitrated
// round-robin onto one single-ported, word-addressed array with one grant per
// cycle. Read data returns on the granted port RESP_LATENCY cycles after the
// grant. Writes honour byte enables and produce no response.
module hwpe_tcdm_responder_bank #(
   parameter int unsigned NP           = 3,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned MEM_WORDS    = 1024,
   parameter int unsigned RESP_LATENCY = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           clear_i,
   input  logic                           stall_i,
   input  logic [NP-1:0]                  tcdm_req_i,
   output logic [NP-1:0]                  tcdm_gnt_o,
   input  logic [NP*ADDR_WIDTH-1:0]       tcdm_add_i,
   input  logic [NP-1:0]                  tcdm_wen_i,
   input  logic [NP*DATA_WIDTH/8-1:0]     tcdm_be_i,
   input  logic [NP*DATA_WIDTH-1:0]       tcdm_data_i,
   output logic [NP*DATA_WIDTH-1:0]       tcdm_r_data_o,
   output logic [NP-1:0]                  tcdm_r_valid_o,
   output logic                           busy_o
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned OFFS  = (BYTES > 1) ? $clog2(BYTES) : 0;
   localparam int unsigned IDXW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int unsigned PW    = (NP > 1) ? $clog2(NP) : 1;

   // per-port views of the flattened request buses
   logic [ADDR_WIDTH-1:0] add_a   [NP];
   logic [DATA_WIDTH-1:0] wdata_a [NP];
   logic [BYTES-1:0]      be_a    [NP];

   // arbitration state
   logic [PW-1:0]         ptr_q;
   logic [PW-1:0]         gnt_idx;
   logic                  gnt_any;
   int unsigned           cand;

   // granted request fields
   logic [ADDR_WIDTH-1:0] sel_add;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [BYTES-1:0]      sel_be;
   logic [IDXW-1:0]       widx;
   logic                  rd_grant;
   logic                  wr_grant;
   logic                  unused_add;

   // storage and response pipeline
   logic [DATA_WIDTH-1:0] mem      [MEM_WORDS];
   logic [RESP_LATENCY-1:0] pipe_v;
   logic [PW-1:0]         pipe_p   [RESP_LATENCY];
   logic [DATA_WIDTH-1:0] pipe_d   [RESP_LATENCY];
   logic [DATA_WIDTH-1:0] r_data_q [NP];
   logic                  resp_v;
   logic [PW-1:0]         resp_p;
   logic [DATA_WIDTH-1:0] resp_d;

   // split flattened port buses into per-port arrays
   always_comb begin
      for (int unsigned k = 0; k < NP; k++) begin
         add_a[k]   = tcdm_add_i[k*ADDR_WIDTH +: ADDR_WIDTH];
         wdata_a[k] = tcdm_data_i[k*DATA_WIDTH +: DATA_WIDTH];
         be_a[k]    = tcdm_be_i[k*BYTES +: BYTES];
      end
   end

   // round-robin pick: first requester at or after the pointer, with wrap
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = 0;
      if (rst_ni && !clear_i && !stall_i) begin
         for (int unsigned i = 0; i < NP; i++) begin
            cand = (32'(ptr_q) + i) % NP;
            if (!gnt_any && tcdm_req_i[PW'(cand)]) begin
               gnt_any = 1'b1;
               gnt_idx = PW'(cand);
            end
         end
      end
   end

   assign tcdm_gnt_o = gnt_any ? (NP'(1) << gnt_idx) : '0;

   assign sel_add    = add_a[gnt_idx];
   assign sel_wdata  = wdata_a[gnt_idx];
   assign sel_be     = be_a[gnt_idx];
   assign widx       = sel_add[IDXW+OFFS-1:OFFS];
   assign rd_grant   = gnt_any &  tcdm_wen_i[gnt_idx];
   assign wr_grant   = gnt_any & ~tcdm_wen_i[gnt_idx];
   // byte-offset and upper address bits are deliberately ignored (address wrap)
   assign unused_add = ^sel_add;

   // byte-masked write at the end of the grant cycle; array is never reset
   always_ff @(posedge clk_i) begin
      if (wr_grant) begin
         for (int unsigned b = 0; b < BYTES; b++) begin
            if (sel_be[b]) begin
               mem[widx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
         end
      end
   end

   // pointer update, response pipeline shift and per-port read-data hold
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ptr_q  <= '0;
         pipe_v <= '0;
         for (int unsigned s = 0; s < RESP_LATENCY; s++) begin
            pipe_p[s] <= '0;
            pipe_d[s] <= '0;
         end
         for (int unsigned k = 0; k < NP; k++) begin
            r_data_q[k] <= '0;
         end
      end else begin
         if (clear_i) begin
            ptr_q <= '0;
         end else if (gnt_any) begin
            ptr_q <= (gnt_idx == PW'(NP-1)) ? '0 : gnt_idx + 1'b1;
         end
         pipe_v[0] <= rd_grant & ~clear_i;
         if (rd_grant) begin
            pipe_p[0] <= gnt_idx;
            pipe_d[0] <= mem[widx];
         end
         for (int unsigned s = 1; s < RESP_LATENCY; s++) begin
            pipe_v[s] <= pipe_v[s-1] & ~clear_i;
            pipe_p[s] <= pipe_p[s-1];
            pipe_d[s] <= pipe_d[s-1];
         end
         if (resp_v) begin
            r_data_q[resp_p] <= resp_d;
         end
      end
   end

   assign resp_v = pipe_v[RESP_LATENCY-1];
   assign resp_p = pipe_p[RESP_LATENCY-1];
   assign resp_d = pipe_d[RESP_LATENCY-1];
   assign busy_o = |pipe_v;

   // last pipeline stage drives the responding port; others show held data
   always_comb begin
      tcdm_r_valid_o = '0;
      if (resp_v) begin
         tcdm_r_valid_o[resp_p] = 1'b1;
      end
      for (int unsigned k = 0; k < NP; k++) begin
         tcdm_r_data_o[k*DATA_WIDTH +: DATA_WIDTH] =
            (resp_v && (resp_p == PW'(k))) ? resp_d : r_data_q[k];
      end
   end

endmodule

// File: tb/tb_hwpe_tcdm_responder_bank.sv
// Directed bench for hwpe_tcdm_responder_bank. Two instances share all inputs:
// one with RESP_LATENCY=1 and one with RESP_LATENCY=3. Expected responses are
// queued when a grant is expected and checked when they fall due.
module tb_hwpe_tcdm_responder_bank;

   typedef struct {
      logic [1:0]  port;
      logic [31:0] data;
      int          due;
   } resp_t;

   logic        clk = 1'b0;
   logic        rstn, clr, stall;
   logic [2:0]  req, wen;
   logic [31:0] add   [3];
   logic [31:0] wdata [3];
   logic [3:0]  be    [3];

   logic [95:0] add_bus, data_bus;
   logic [11:0] be_bus;
   logic [2:0]  gnt1, gnt3, rv1, rv3;
   logic [95:0] rdata1, rdata3;
   logic        busy1, busy3;

   logic [31:0] mdl  [1024];
   logic [31:0] last [2][3];
   resp_t       q    [2][$];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   assign add_bus  = {add[2], add[1], add[0]};
   assign data_bus = {wdata[2], wdata[1], wdata[0]};
   assign be_bus   = {be[2], be[1], be[0]};

   hwpe_tcdm_responder_bank #(
      .NP(3), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(1024), .RESP_LATENCY(1)
   ) dut1 (
      .clk_i(clk), .rst_ni(rstn), .clear_i(clr), .stall_i(stall),
      .tcdm_req_i(req), .tcdm_gnt_o(gnt1), .tcdm_add_i(add_bus),
      .tcdm_wen_i(wen), .tcdm_be_i(be_bus), .tcdm_data_i(data_bus),
      .tcdm_r_data_o(rdata1), .tcdm_r_valid_o(rv1), .busy_o(busy1)
   );

   hwpe_tcdm_responder_bank #(
      .NP(3), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(1024), .RESP_LATENCY(3)
   ) dut3 (
      .clk_i(clk), .rst_ni(rstn), .clear_i(clr), .stall_i(stall),
      .tcdm_req_i(req), .tcdm_gnt_o(gnt3), .tcdm_add_i(add_bus),
      .tcdm_wen_i(wen), .tcdm_be_i(be_bus), .tcdm_data_i(data_bus),
      .tcdm_r_data_o(rdata3), .tcdm_r_valid_o(rv3), .busy_o(busy3)
   );

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_resp(input logic d, input string tag);
      resp_t       e;
      logic [2:0]  exp_rv;
      logic [2:0]  rv;
      logic [95:0] rd;
      logic        bsy;
      rv  = d ? rv3 : rv1;
      rd  = d ? rdata3 : rdata1;
      bsy = d ? busy3 : busy1;
      exp_rv = '0;
      if (q[d].size() > 0 && q[d][0].due == cyc) begin
         e = q[d].pop_front();
         exp_rv[e.port] = 1'b1;
         last[d][e.port] = e.data;
      end
      chk({tag, d ? " L3 r_valid" : " L1 r_valid"}, 96'(rv), 96'(exp_rv));
      chk({tag, d ? " L3 r_data" : " L1 r_data"}, rd, {last[d][2], last[d][1], last[d][0]});
      chk({tag, d ? " L3 busy" : " L1 busy"}, 96'(bsy),
          96'((exp_rv != 3'b000) || (q[d].size() != 0)));
   endtask

   // one clock cycle: check grants, update model, advance, check responses
   task automatic step(input logic [2:0] exp_gnt, input string tag);
      resp_t e;
      #1;
      chk({tag, " L1 gnt"}, 96'(gnt1), 96'(exp_gnt));
      chk({tag, " L3 gnt"}, 96'(gnt3), 96'(exp_gnt));
      for (int k = 0; k < 3; k++) begin
         if (exp_gnt[k]) begin
            if (wen[k]) begin
               e.port = 2'(k);
               e.data = mdl[add[k][11:2]];
               e.due  = cyc + 1;
               q[0].push_back(e);
               e.due  = cyc + 3;
               q[1].push_back(e);
            end else begin
               for (int b = 0; b < 4; b++) begin
                  if (be[k][b]) mdl[add[k][11:2]][b*8 +: 8] = wdata[k][b*8 +: 8];
               end
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!rstn || clr) begin
         q[0].delete();
         q[1].delete();
      end
      if (!rstn) begin
         for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++) last[i][k] = '0;
      end
      chk_resp(1'b0, tag);
      chk_resp(1'b1, tag);
   endtask

   task automatic rd(input int k, input logic [31:0] a);
      wen[k] = 1'b1; add[k] = a; be[k] = 4'h0; wdata[k] = '0;
   endtask

   task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      wen[k] = 1'b0; add[k] = a; be[k] = m; wdata[k] = d;
   endtask

   initial begin
      rstn = 1'b0; clr = 1'b0; stall = 1'b0; req = 3'b111; wen = 3'b111;
      for (int k = 0; k < 3; k++) begin
         add[k] = '0; wdata[k] = '0; be[k] = '0;
         last[0][k] = '0; last[1][k] = '0;
      end

      // reset: no grants while held, outputs cleared
      step(3'b000, "reset0");
      step(3'b000, "reset1");
      rstn = 1'b1;

      // write then read back on another port
      wr(0, 32'h40, 32'hDEADBEEF, 4'hF); req = 3'b001;
      step(3'b001, "wr40");
      rd(1, 32'h40); req = 3'b010;
      step(3'b010, "rd40");
      chk("rd40 value", 96'(rdata1[63:32]), 96'(32'hDEADBEEF));
      req = 3'b000;
      repeat (3) step(3'b000, "drain_a");

      // byte-enable merge
      wr(2, 32'h8, 32'h11223344, 4'hF); req = 3'b100;
      step(3'b100, "wr8_full");
      wr(0, 32'h8, 32'hAABBCCDD, 4'h5); req = 3'b001;
      step(3'b001, "wr8_be5");
      rd(1, 32'h8); req = 3'b010;
      step(3'b010, "rd8");
      chk("be merge", 96'(rdata1[63:32]), 96'(32'h11BB33DD));
      req = 3'b000;
      repeat (3) step(3'b000, "drain_b");

      // round robin from reset with all ports reading
      rstn = 1'b0;
      step(3'b000, "reset2");
      rstn = 1'b1;
      rd(0, 32'h40); rd(1, 32'h8); rd(2, 32'h40); req = 3'b111;
      step(3'b001, "rr0");
      step(3'b010, "rr1");
      step(3'b100, "rr2");
      step(3'b001, "rr3");
      step(3'b010, "rr4");
      step(3'b100, "rr5");
      req = 3'b000;
      repeat (3) step(3'b000, "drain_c");

      // stall with all requesting; in-flight read drains; pointer held
      req = 3'b001;
      step(3'b001, "pre_stall");
      stall = 1'b1; req = 3'b111;
      repeat (4) step(3'b000, "stall_all");
      stall = 1'b0;
      step(3'b010, "post_stall_ptr");
      // stall with only port 2 requesting
      stall = 1'b1; req = 3'b100;
      repeat (4) step(3'b000, "stall_p2");
      stall = 1'b0;
      step(3'b100, "post_stall_p2");
      req = 3'b111;
      step(3'b001, "ptr_wrap");
      req = 3'b000;
      repeat (3) step(3'b000, "drain_d");

      // back-to-back reads on port 0, visible as a latency-3 burst
      for (int i = 0; i < 5; i++) begin
         wr(0, 32'(i*4), 32'hC0DE0000 + 32'(i), 4'hF); req = 3'b001;
         step(3'b001, "burst_wr");
      end
      for (int i = 0; i < 5; i++) begin
         rd(0, 32'(i*4)); req = 3'b001;
         step(3'b001, "burst_rd");
      end
      req = 3'b000;
      repeat (4) step(3'b000, "drain_e");

      // clear flushes in-flight reads and resets the pointer
      rd(0, 32'h0); req = 3'b001;
      step(3'b001, "pre_clear");
      clr = 1'b1; req = 3'b111;
      step(3'b000, "clear");
      clr = 1'b0; req = 3'b101;
      step(3'b001, "post_clear_ptr");
      req = 3'b000;
      repeat (3) step(3'b000, "drain_f");

      // reset mid-operation: in-flight read dropped, write in reset cycle lost
      rd(1, 32'h40); req = 3'b010;
      step(3'b010, "pre_reset");
      rstn = 1'b0; wr(0, 32'h40, 32'h0, 4'hF); req = 3'b001;
      step(3'b000, "reset_mid");
      rstn = 1'b1; req = 3'b000;
      repeat (3) step(3'b000, "post_reset");
      rd(0, 32'h40); rd(1, 32'h8); rd(2, 32'h40); req = 3'b111;
      step(3'b001, "post_reset_ptr");
      req = 3'b000;
      repeat (3) step(3'b000, "drain_g");
      chk("mem kept", 96'(rdata1[31:0]), 96'(32'hDEADBEEF));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
